// File: rtl/ex_pkg.sv
// ex_pkg -- shared types and constants for the execute stage.
//   Word_t / Bit_t / Reg_addr_t : datapath word, single bit, GPR index
//   Oper_t                      : operation encoding from the id/ex register
//   Div_state_t                 : iterative divider states
//   DIV_CYCLES_DEFAULT          : default number of divider iterations
//   ZERO_WORD                   : HI/LO reset value
//   negate_word()               : two's-complement negate of a word
package ex_pkg;

    typedef logic [31:0] Word_t;
    typedef logic        Bit_t;
    typedef logic [4:0]  Reg_addr_t;

    typedef enum logic [4:0] {
        OP_NOP   = 5'd0,
        OP_ORI   = 5'd1,
        OP_OR    = 5'd2,
        OP_AND   = 5'd3,
        OP_XOR   = 5'd4,
        OP_ADDU  = 5'd5,
        OP_SUBU  = 5'd6,
        OP_SLT   = 5'd7,
        OP_SLTU  = 5'd8,
        OP_SLL   = 5'd9,
        OP_SRL   = 5'd10,
        OP_SRA   = 5'd11,
        OP_MFHI  = 5'd12,
        OP_MFLO  = 5'd13,
        OP_MTHI  = 5'd14,
        OP_MTLO  = 5'd15,
        OP_MULT  = 5'd16,
        OP_MULTU = 5'd17,
        OP_DIV   = 5'd18,
        OP_DIVU  = 5'd19
    } Oper_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } Div_state_t;

    localparam int unsigned DIV_CYCLES_DEFAULT = 32;
    localparam Word_t       ZERO_WORD          = 32'h0000_0000;

    function automatic Word_t negate_word(input Word_t w);
        return ZERO_WORD - w;
    endfunction

endpackage

// File: rtl/ex_if.sv
// ex_if -- id/ex-side bundle of the execute stage.
//   Inputs to EX : oper_i, reg1_i, reg2_i, wreg_write_i, wreg_addr_i, flush_i
//   Outputs of EX: wreg_write_o, wreg_addr_o, wreg_data_o (forwarding/ex-mem
//                  result) and stall_req_o (hold PC, IF/ID, ID/EX)
//   modport master: upstream pipeline side; modport slave: the ex block.
interface ex_if;
    import ex_pkg::*;

    Oper_t     oper_i;
    Word_t     reg1_i;
    Word_t     reg2_i;
    Bit_t      wreg_write_i;
    Reg_addr_t wreg_addr_i;
    Bit_t      flush_i;

    Bit_t      wreg_write_o;
    Reg_addr_t wreg_addr_o;
    Word_t     wreg_data_o;
    Bit_t      stall_req_o;

    modport master (
        output oper_i, reg1_i, reg2_i, wreg_write_i, wreg_addr_i, flush_i,
        input  wreg_write_o, wreg_addr_o, wreg_data_o, stall_req_o
    );

    modport slave (
        input  oper_i, reg1_i, reg2_i, wreg_write_i, wreg_addr_i, flush_i,
        output wreg_write_o, wreg_addr_o, wreg_data_o, stall_req_o
    );

endinterface

// File: rtl/ex_div_unit.sv
// div_unit -- iterative restoring divider, one quotient bit per cycle.
//   clk, rst (async, active-low)
//   start_i      : divide requested (sampled in IDLE)
//   signed_en_i  : signed divide (DIV) vs unsigned (DIVU)
//   dividend_i   : dividend, divisor_i : divisor
//   abort_i      : return to IDLE at once, no result
//   busy_o       : stall request (IDLE with start, or BUSY)
//   done_o       : result valid this cycle
//   quotient_o   : sign-corrected quotient (all ones on divide by zero)
//   remainder_o  : sign-corrected remainder (dividend on divide by zero)
module div_unit
    import ex_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  start_i,
    input  logic  signed_en_i,
    input  Word_t dividend_i,
    input  Word_t divisor_i,
    input  logic  abort_i,
    output logic  busy_o,
    output logic  done_o,
    output Word_t quotient_o,
    output Word_t remainder_o
);

    localparam int unsigned    CNT_W    = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    Div_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    Word_t            quo_q;
    Word_t            rem_q;
    Word_t            dvs_q;
    logic             neg_quo_q;
    logic             neg_rem_q;

    logic  dvd_neg;
    logic  dvs_neg;
    Word_t dvd_mag;
    Word_t dvs_mag;
    logic  [32:0] trial;
    logic  load;

    // Work on magnitudes; the signs are re-applied once in DONE.
    assign dvd_neg = signed_en_i & dividend_i[31];
    assign dvs_neg = signed_en_i & divisor_i[31];
    assign dvd_mag = dvd_neg ? negate_word(dividend_i) : dividend_i;
    assign dvs_mag = dvs_neg ? negate_word(divisor_i)  : divisor_i;

    // Partial remainder is always below the divisor, so bit 32 of the trial
    // difference is a clean borrow flag.
    assign trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};
    assign load  = (state_q == DIV_IDLE) && start_i && !abort_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
        end else if (abort_i) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start_i) begin
                        state_q <= (divisor_i == ZERO_WORD) ? DIV_DONE : DIV_BUSY;
                    end
                    cnt_q <= '0;
                end
                DIV_BUSY: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DIV_DONE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= DIV_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Operand latches and shift-subtract datapath; only meaningful while the
    // FSM is out of IDLE, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (load) begin
            dvs_q <= dvs_mag;
            if (divisor_i == ZERO_WORD) begin
                quo_q     <= '1;
                rem_q     <= dividend_i;
                neg_quo_q <= 1'b0;
                neg_rem_q <= 1'b0;
            end else begin
                quo_q     <= dvd_mag;
                rem_q     <= ZERO_WORD;
                neg_quo_q <= dvd_neg ^ dvs_neg;
                neg_rem_q <= dvd_neg;
            end
        end else if (state_q == DIV_BUSY) begin
            if (!trial[32]) begin
                rem_q <= trial[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= {rem_q[30:0], quo_q[31]};
                quo_q <= {quo_q[30:0], 1'b0};
            end
        end
    end

    assign busy_o      = !abort_i && (((state_q == DIV_IDLE) && start_i) || (state_q == DIV_BUSY));
    assign done_o      = (state_q == DIV_DONE);
    assign quotient_o  = neg_quo_q ? negate_word(quo_q) : quo_q;
    assign remainder_o = neg_rem_q ? negate_word(rem_q) : rem_q;

endmodule

// File: rtl/ex.sv
// ex -- execute stage: ALU result mux, 32x32 multiplier, HI/LO registers and
// (optionally) the iterative divider.
//   clk  : pipeline clock
//   rst  : asynchronous active-low reset; forces all outputs to zero
//   bus  : ex_if.slave -- operation/operands/destination/flush in,
//          GPR write result (also EX forwarding source) and stall request out
// Build option: define CPU_DIV_EN to build the divider; otherwise DIV/DIVU
// act as NOP and stall_req_o is constant 0.
module ex
    import ex_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    ex_if.slave  bus
);

    if (DIV_CYCLES < 2) begin : g_cfg_check
        $error("DIV_CYCLES must be at least 2");
    end

    Word_t hi_q, hi_d;
    Word_t lo_q, lo_d;
    Word_t alu_data;
    logic  stall;
    logic  div_done;
    Word_t div_quo;
    Word_t div_rem;

    logic        [4:0]  sh;
    logic signed [31:0] r1_s;
    logic signed [31:0] r2_s;
    logic signed [63:0] mul_a_s;
    logic signed [63:0] mul_b_s;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;

    assign sh      = bus.reg1_i[4:0];
    assign r1_s    = bus.reg1_i;
    assign r2_s    = bus.reg2_i;
    assign mul_a_s = {{32{bus.reg1_i[31]}}, bus.reg1_i};
    assign mul_b_s = {{32{bus.reg2_i[31]}}, bus.reg2_i};
    assign prod_s  = mul_a_s * mul_b_s;
    assign prod_u  = {32'b0, bus.reg1_i} * {32'b0, bus.reg2_i};

`ifdef CPU_DIV_EN
    logic div_start;
    logic div_busy;

    assign div_start = (bus.oper_i == OP_DIV) || (bus.oper_i == OP_DIVU);

    div_unit #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .start_i     (div_start),
        .signed_en_i (bus.oper_i == OP_DIV),
        .dividend_i  (bus.reg1_i),
        .divisor_i   (bus.reg2_i),
        .abort_i     (bus.flush_i),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    assign stall = div_busy;
`else
    assign stall    = 1'b0;
    assign div_done = 1'b0;
    assign div_quo  = ZERO_WORD;
    assign div_rem  = ZERO_WORD;
`endif

    always_comb begin
        alu_data = ZERO_WORD;
        case (bus.oper_i)
            OP_ORI, OP_OR: alu_data = bus.reg1_i | bus.reg2_i;
            OP_AND:        alu_data = bus.reg1_i & bus.reg2_i;
            OP_XOR:        alu_data = bus.reg1_i ^ bus.reg2_i;
            OP_ADDU:       alu_data = bus.reg1_i + bus.reg2_i;
            OP_SUBU:       alu_data = bus.reg1_i - bus.reg2_i;
            OP_SLT:        alu_data = {31'b0, r1_s < r2_s};
            OP_SLTU:       alu_data = {31'b0, bus.reg1_i < bus.reg2_i};
            OP_SLL:        alu_data = bus.reg2_i << sh;
            OP_SRL:        alu_data = bus.reg2_i >> sh;
            OP_SRA:        alu_data = r2_s >>> sh;
            OP_MFHI:       alu_data = hi_q;
            OP_MFLO:       alu_data = lo_q;
            default:       alu_data = ZERO_WORD;
        endcase
    end

    // A divide result in DONE takes priority; its oper_i is still DIV/DIVU
    // so it cannot collide with a MULT/MTHI/MTLO commit.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (!bus.flush_i && !stall) begin
            if (div_done) begin
                hi_d = div_rem;
                lo_d = div_quo;
            end else begin
                case (bus.oper_i)
                    OP_MULT:  {hi_d, lo_d} = prod_s;
                    OP_MULTU: {hi_d, lo_d} = prod_u;
                    OP_MTHI:  hi_d = bus.reg1_i;
                    OP_MTLO:  lo_d = bus.reg1_i;
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= ZERO_WORD;
            lo_q <= ZERO_WORD;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Outputs are gated by rst so reset clears them without waiting for a clock.
    assign bus.wreg_write_o = rst & bus.wreg_write_i & ~bus.flush_i & ~stall;
    assign bus.wreg_addr_o  = rst ? bus.wreg_addr_i : '0;
    assign bus.wreg_data_o  = rst ? alu_data : ZERO_WORD;
    assign bus.stall_req_o  = rst & stall;

endmodule

// File: tb/tb_ex.sv
// tb_ex -- self-checking bench for the execute stage. Works for either build
// of the divider (CPU_DIV_EN defined or not).
module tb_ex;
    import ex_pkg::*;

`ifdef CPU_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif
    localparam int DIV_STALL = 33;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_if bus ();

    ex #(.DIV_CYCLES(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    Oper_t       c_op;
    logic [31:0] c_a;
    logic [31:0] c_b;
    logic        c_we;
    logic [4:0]  c_wa;
    logic        c_fl;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    Oper_t alu_ops [16] = '{OP_NOP, OP_ORI, OP_OR, OP_AND, OP_XOR, OP_ADDU, OP_SUBU, OP_SLT,
                            OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_MFHI, OP_MFLO, OP_MULT, OP_MULTU};

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, o, e);
        end
    endtask

    task automatic drive(input Oper_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic we, input logic [4:0] wa, input logic fl);
        c_op = op; c_a = a; c_b = b; c_we = we; c_wa = wa; c_fl = fl;
        bus.oper_i       = op;
        bus.reg1_i       = a;
        bus.reg2_i       = b;
        bus.wreg_write_i = we;
        bus.wreg_addr_i  = wa;
        bus.flush_i      = fl;
    endtask

    function automatic logic [31:0] exp_alu(input Oper_t op, input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] hi, input logic [31:0] lo);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_ORI, OP_OR: return a | b;
            OP_AND:        return a & b;
            OP_XOR:        return a ^ b;
            OP_ADDU:       return 32'(longint'({32'b0, a}) + longint'({32'b0, b}));
            OP_SUBU:       return 32'(longint'({32'b0, a}) - longint'({32'b0, b}));
            OP_SLT:        return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU:       return (a < b) ? 32'd1 : 32'd0;
            OP_SLL:        return 32'({32'b0, b} << a[4:0]);
            OP_SRL:        return b >> a[4:0];
            OP_SRA:        return 32'(sb >>> a[4:0]);
            OP_MFHI:       return hi;
            OP_MFLO:       return lo;
            default:       return 32'd0;
        endcase
    endfunction

    // {remainder, quotient}
    function automatic logic [63:0] div_model(input Oper_t op, input logic [31:0] a, input logic [31:0] b);
        longint x;
        longint y;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == OP_DIV) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'b0, a});
            y = longint'({32'b0, b});
        end
        return {32'(x % y), 32'(x / y)};
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One non-divide cycle: check outputs mid-cycle, take the edge, apply HI/LO effects.
    task automatic alu_cycle(input string tag, output logic [31:0] obs);
        longint sa;
        longint sb;
        #3;
        obs = bus.wreg_data_o;
        chk({tag, ".data"},  bus.wreg_data_o, exp_alu(c_op, c_a, c_b, m_hi, m_lo));
        chk({tag, ".we"},    32'(bus.wreg_write_o), 32'(c_we & ~c_fl));
        chk({tag, ".addr"},  32'(bus.wreg_addr_o), 32'(c_wa));
        chk({tag, ".stall"}, 32'(bus.stall_req_o), 32'd0);
        @(posedge clk); #1;
        if (!c_fl) begin
            sa = longint'($signed(c_a));
            sb = longint'($signed(c_b));
            case (c_op)
                OP_MULT:  {m_hi, m_lo} = sa * sb;
                OP_MULTU: {m_hi, m_lo} = {32'b0, c_a} * {32'b0, c_b};
                OP_MTHI:  m_hi = c_a;
                OP_MTLO:  m_lo = c_a;
                default:  ;
            endcase
        end
    endtask

    // Divide held until it finishes; flush_at is the cycle index (0 = first
    // cycle presented, n = the result cycle) at which flush_i is raised, or -1.
    task automatic do_div(input string tag, input Oper_t op, input logic [31:0] a,
                          input logic [31:0] b, input int flush_at);
        int n;
        logic [63:0] res;
        n = DIV_ON ? ((b == 32'd0) ? 1 : DIV_STALL) : 0;
        drive(op, a, b, 1'b1, 5'd9, 1'b0);
        for (int i = 0; i <= n; i++) begin
            if (i == flush_at) begin
                bus.flush_i = 1'b1;
                c_fl = 1'b1;
            end
            #3;
            chk({tag, ".stall"}, 32'(bus.stall_req_o), (i < n && i != flush_at) ? 32'd1 : 32'd0);
            chk({tag, ".we"},    32'(bus.wreg_write_o), (i == n && i != flush_at) ? 32'd1 : 32'd0);
            chk({tag, ".data"},  bus.wreg_data_o, 32'd0);
            @(posedge clk); #1;
            if (i == flush_at) break;
            if (i == n && DIV_ON) begin
                res  = div_model(op, a, b);
                m_hi = res[63:32];
                m_lo = res[31:0];
            end
        end
        drive(OP_NOP, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] obs;
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        Oper_t       op;

        m_hi = 32'd0;
        m_lo = 32'd0;
        rst  = 1'b0;
        drive(OP_OR, 32'h0000_1234, 32'h0000_00F0, 1'b1, 5'd5, 1'b0);

        // Outputs forced to zero while in reset.
        #3;
        chk("rst.we",    32'(bus.wreg_write_o), 32'd0);
        chk("rst.addr",  32'(bus.wreg_addr_o), 32'd0);
        chk("rst.data",  bus.wreg_data_o, 32'd0);
        chk("rst.stall", 32'(bus.stall_req_o), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;

        drive(OP_MFHI, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        alu_cycle("rst.hi", obs);
        chk("rst.hi.zero", obs, 32'd0);
        drive(OP_MFLO, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        alu_cycle("rst.lo", obs);
        chk("rst.lo.zero", obs, 32'd0);

        drive(OP_ORI, 32'h0000_1234, 32'h0000_00F0, 1'b1, 5'd5, 1'b0);
        alu_cycle("ori", obs);
        chk("ori.const", obs, 32'h0000_12F4);

        drive(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 5'd0, 1'b0);
        alu_cycle("mult", obs);
        drive(OP_MFLO, 32'd0, 32'd0, 1'b1, 5'd2, 1'b0);
        alu_cycle("mult.lo", obs);
        chk("mult.lo.const", obs, 32'hFFFF_FFFA);
        drive(OP_MFHI, 32'd0, 32'd0, 1'b1, 5'd3, 1'b0);
        alu_cycle("mult.hi", obs);
        chk("mult.hi.const", obs, 32'hFFFF_FFFF);

        // Boundary ALU cases.
        drive(Oper_t'(5'd27), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd4, 1'b0);
        alu_cycle("unknown", obs);
        drive(OP_OR, 32'hA5A5_0000, 32'h0000_5A5A, 1'b1, 5'd6, 1'b1);
        alu_cycle("flush.or", obs);
        drive(OP_MTHI, 32'h1357_9BDF, 32'd0, 1'b0, 5'd0, 1'b1);
        alu_cycle("flush.mthi", obs);
        drive(OP_SLT, 32'h8000_0000, 32'd1, 1'b1, 5'd0, 1'b0);
        alu_cycle("slt.min", obs);
        drive(OP_SLTU, 32'h8000_0000, 32'd1, 1'b1, 5'd1, 1'b0);
        alu_cycle("sltu.min", obs);
        drive(OP_SRA, 32'h0000_003F, 32'h8000_0001, 1'b1, 5'd7, 1'b0);
        alu_cycle("sra.31", obs);
        drive(OP_SLL, 32'hFFFF_FFE3, 32'h1234_5678, 1'b1, 5'd8, 1'b0);
        alu_cycle("sll.hi_bits", obs);
        drive(OP_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0, 5'd0, 1'b0);
        alu_cycle("mtlo", obs);
        drive(OP_MFLO, 32'd0, 32'd0, 1'b1, 5'd1, 1'b0);
        alu_cycle("mtlo.rd", obs);

        // Signed divide -7 / 2.
        prev_hi = m_hi;
        prev_lo = m_lo;
        do_div("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, -1);
        drive(OP_MFLO, 32'd0, 32'd0, 1'b1, 5'd1, 1'b0);
        alu_cycle("div.lo", obs);
        chk("div.lo.const", obs, DIV_ON ? 32'hFFFF_FFFD : prev_lo);
        drive(OP_MFHI, 32'd0, 32'd0, 1'b1, 5'd1, 1'b0);
        alu_cycle("div.hi", obs);
        chk("div.hi.const", obs, DIV_ON ? 32'hFFFF_FFFF : prev_hi);

        // Divide by zero.
        prev_hi = m_hi;
        prev_lo = m_lo;
        do_div("divz", OP_DIVU, 32'd100, 32'd0, -1);
        drive(OP_MFLO, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        alu_cycle("divz.lo", obs);
        chk("divz.lo.const", obs, DIV_ON ? 32'hFFFF_FFFF : prev_lo);
        drive(OP_MFHI, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        alu_cycle("divz.hi", obs);
        chk("divz.hi.const", obs, DIV_ON ? 32'd100 : prev_hi);

        // Flush at BUSY cycle 10, then a clean rerun.
        prev_hi = m_hi;
        prev_lo = m_lo;
        do_div("divf", OP_DIVU, 32'h8000_0000, 32'd3, 11);
        drive(OP_MFLO, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        alu_cycle("divf.lo", obs);
        chk("divf.lo.kept", obs, prev_lo);
        drive(OP_MFHI, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        alu_cycle("divf.hi", obs);
        chk("divf.hi.kept", obs, prev_hi);
        prev_hi = m_hi;
        prev_lo = m_lo;
        do_div("divr", OP_DIVU, 32'h8000_0000, 32'd3, -1);
        drive(OP_MFLO, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        alu_cycle("divr.lo", obs);
        chk("divr.lo.const", obs, DIV_ON ? 32'h2AAA_AAAA : prev_lo);
        drive(OP_MFHI, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        alu_cycle("divr.hi", obs);
        chk("divr.hi.const", obs, DIV_ON ? 32'd2 : prev_hi);

        // Flush coinciding with the result cycle: HI/LO must not change.
        do_div("divfd", OP_DIV, 32'd9, 32'd4, DIV_ON ? DIV_STALL : 0);
        drive(OP_MFLO, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        alu_cycle("divfd.lo", obs);

        // Signed overflow case -2^31 / -1.
        do_div("divov", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        drive(OP_MFLO, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        alu_cycle("divov.lo", obs);
        drive(OP_MFHI, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        alu_cycle("divov.hi", obs);

        // Randomized mix of ALU ops, flushes and divides.
        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                op = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU;
                do_div("rdiv", op, rand_word(), ($urandom_range(0, 3) == 0) ? 32'd0 : rand_word(), -1);
            end else begin
                drive(alu_ops[$urandom_range(0, 15)], rand_word(), rand_word(),
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                      ($urandom_range(0, 7) == 0));
                alu_cycle("rnd", obs);
            end
        end

        // Asynchronous reset at BUSY cycle 20 of a divide.
        drive(OP_MULTU, 32'hDEAD_BEEF, 32'h0000_1001, 1'b0, 5'd0, 1'b0);
        alu_cycle("prerst", obs);
        drive(OP_DIVU, 32'h8000_0000, 32'd3, 1'b1, 5'd7, 1'b0);
        repeat (21) @(posedge clk);
        #4;
        rst = 1'b0;
        #1;
        chk("arst.we",    32'(bus.wreg_write_o), 32'd0);
        chk("arst.addr",  32'(bus.wreg_addr_o), 32'd0);
        chk("arst.data",  bus.wreg_data_o, 32'd0);
        chk("arst.stall", 32'(bus.stall_req_o), 32'd0);
        @(posedge clk); #1;
        rst  = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        drive(OP_MFHI, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        alu_cycle("arst.hi", obs);
        chk("arst.hi.zero", obs, 32'd0);
        drive(OP_MFLO, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        alu_cycle("arst.lo", obs);
        chk("arst.lo.zero", obs, 32'd0);
        do_div("postrst", OP_DIV, 32'd1000, 32'hFFFF_FFF9, -1);
        drive(OP_MFLO, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        alu_cycle("postrst.lo", obs);
        drive(OP_MFHI, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        alu_cycle("postrst.hi", obs);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
